// File: rtl/llr_loader.sv
// Write-side loader for the LLR RAM: accepts a valid/ready stream of wide
// signed LLRs, saturates them and writes one frame from address 0 upward.
module llr_loader #(
    parameter int IN_WIDTH   = 10,
    parameter int LLR_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_last,
    output logic                        ram_wren,
    output logic [ADDR_WIDTH-1:0]       ram_wraddress,
    output logic [LLR_WIDTH-1:0]        ram_data,
    output logic                        frame_valid,
    output logic                        frame_err,
    output logic [ADDR_WIDTH:0]         frame_len,
    input  logic                        frame_ack
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'(2 ** (LLR_WIDTH - 1) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        HOLD
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] count, next_count;
    logic [CNT_W-1:0] next_frame_len;
    logic             next_frame_valid;
    logic             next_frame_err;
    logic             next_in_ready;
    logic             accept;
    logic             at_last;

    // Symmetric clamp so that the most negative code never reaches the RAM.
    function automatic logic [LLR_WIDTH-1:0] saturate(input logic signed [IN_WIDTH-1:0] v);
        logic signed [IN_WIDTH-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[LLR_WIDTH-1:0];
    endfunction

    assign accept  = in_valid & in_ready;
    assign at_last = (count == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        next_count       = count;
        next_frame_valid = frame_valid;
        next_frame_err   = frame_err;
        next_frame_len   = frame_len;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (in_last || at_last) begin
                        next_state     = DONE;
                        next_count     = '0;
                        next_frame_len = count + CNT_W'(1);
                        // Error when in_last and the final slot disagree.
                        next_frame_err = in_last ^ at_last;
                    end else begin
                        next_state = LOAD;
                        next_count = count + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                next_state = HOLD;
            end
            HOLD: begin
                next_frame_valid = 1'b1;
                if (frame_ack && frame_valid) begin
                    next_state       = IDLE;
                    next_frame_valid = 1'b0;
                    next_frame_err   = 1'b0;
                    next_frame_len   = '0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        next_in_ready = (next_state == IDLE) || (next_state == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            in_ready    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_len   <= '0;
        end else begin
            count       <= next_count;
            in_ready    <= next_in_ready;
            frame_valid <= next_frame_valid;
            frame_err   <= next_frame_err;
            frame_len   <= next_frame_len;
        end
    end

    // Registered write port: one cycle from accepted beat to RAM strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
        end else begin
            ram_wren <= accept;
            if (accept) begin
                ram_wraddress <= count[ADDR_WIDTH-1:0];
                ram_data      <= saturate(in_data);
            end
        end
    end

endmodule

// File: tb/tb_llr_loader.sv
// Self-checking bench for llr_loader: frame-level reference model, saturation
// vector table and hand-written hold/ack/reset sequences.
module tb_llr_loader;

    localparam int IN_W = 10;
    localparam int LW   = 8;
    localparam int AW   = 8;
    localparam int FL   = 256;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_data;
    logic                   in_last;
    logic                   ram_wren;
    logic [AW-1:0]          ram_wraddress;
    logic [LW-1:0]          ram_data;
    logic                   frame_valid;
    logic                   frame_err;
    logic [AW:0]            frame_len;
    logic                   frame_ack;

    llr_loader #(
        .IN_WIDTH  (IN_W),
        .LLR_WIDTH (LW),
        .ADDR_WIDTH(AW),
        .FRAME_LEN (FL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .ram_wren     (ram_wren),
        .ram_wraddress(ram_wraddress),
        .ram_data     (ram_data),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .frame_len    (frame_len),
        .frame_ack    (frame_ack)
    );

    typedef struct {
        int         din;
        logic [7:0] exp;
    } sat_vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         frame_data [FL];
    logic [7:0] ram_model  [FL];
    logic [7:0] ram_ref    [FL];
    logic [7:0] got_addr [$];
    logic [7:0] got_data [$];
    int         got_cyc  [$];
    sat_vec_t   sat_tab  [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every RAM strobe lands in the RAM image and the log.
    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            got_addr.push_back(ram_wraddress);
            got_data.push_back(ram_data);
            got_cyc.push_back(cyc);
            ram_model[ram_wraddress] = ram_data;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one beat and wait (bounded) until it is accepted; returns at the
    // falling edge right after the accepting rising edge.
    task automatic applyStimulus(input int d, input bit last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(d);
        in_last  = last;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drive one frame from frame_data and check writes and frame status
    // against the frame rules: end at in_last or slot FL-1, whichever first.
    task automatic runFrame(input string tag, input int last_idx, input int idle_pct, input bit check_consec);
        int k;
        int exp_len;
        int g;
        bit exp_err;
        k       = (last_idx >= 0 && last_idx < FL - 1) ? last_idx : FL - 1;
        exp_len = k + 1;
        exp_err = (last_idx != FL - 1);
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        for (int i = 0; i <= k; i++) begin
            g = 0;
            while (idle_pct > 0 && g < 8 && $urandom_range(0, 99) < idle_pct) begin
                @(negedge clk);
                g++;
            end
            applyStimulus(frame_data[i], (i == last_idx));
        end
        checkOutput({tag, "_ready_after_last"}, in_ready, 0);
        checkOutput({tag, "_valid_t1"}, frame_valid, 0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checkOutput({tag, "_valid_t2"}, frame_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_valid_t3"}, frame_valid, 1);
        checkOutput({tag, "_frame_len"}, frame_len, exp_len);
        checkOutput({tag, "_frame_err"}, frame_err, exp_err);
        checkOutput({tag, "_ready_hold"}, in_ready, 0);
        checkOutput({tag, "_n_writes"}, got_addr.size(), exp_len);
        for (int i = 0; i < exp_len && i < got_addr.size(); i++) begin
            checkOutput($sformatf("%s_addr[%0d]", tag, i), got_addr[i], i);
            checkOutput($sformatf("%s_data[%0d]", tag, i), got_data[i], clamp(frame_data[i]) & 255);
            if (check_consec)
                checkOutput($sformatf("%s_cycle[%0d]", tag, i), got_cyc[i] - got_cyc[0], i);
        end
    endtask

    task automatic releaseFrame(input string tag);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checkOutput({tag, "_rel_valid"}, frame_valid, 0);
        checkOutput({tag, "_rel_err"}, frame_err, 0);
        checkOutput({tag, "_rel_len"}, frame_len, 0);
        checkOutput({tag, "_rel_ready"}, in_ready, 1);
    endtask

    initial begin
        int diff;

        sat_tab[0]  = '{300,  8'h7F};
        sat_tab[1]  = '{-300, 8'h81};
        sat_tab[2]  = '{127,  8'h7F};
        sat_tab[3]  = '{-127, 8'h81};
        sat_tab[4]  = '{0,    8'h00};
        sat_tab[5]  = '{-128, 8'h81};
        sat_tab[6]  = '{128,  8'h7F};
        sat_tab[7]  = '{511,  8'h7F};
        sat_tab[8]  = '{-512, 8'h81};
        sat_tab[9]  = '{1,    8'h01};
        sat_tab[10] = '{-1,   8'hFF};
        sat_tab[11] = '{-100, 8'h9C};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_wren", ram_wren, 0);
        checkOutput("rst_addr", ram_wraddress, 0);
        checkOutput("rst_data", ram_data, 0);
        checkOutput("rst_valid", frame_valid, 0);
        checkOutput("rst_err", frame_err, 0);
        checkOutput("rst_len", frame_len, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("first_edge_ready", in_ready, 1);

        $display("[TB] ack pulse while idle");
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checkOutput("idle_ack_ready", in_ready, 1);
        checkOutput("idle_ack_valid", frame_valid, 0);

        $display("[TB] full ramp frame, continuous valid");
        for (int i = 0; i < FL; i++) frame_data[i] = i - 128;
        runFrame("ramp", FL - 1, 0, 1'b1);

        $display("[TB] hold with in_valid asserted, no ack");
        in_valid = 1'b1;
        in_data  = IN_W'(55);
        repeat (20) begin
            @(negedge clk);
            checkOutput("hold_wren", ram_wren, 0);
            checkOutput("hold_ready", in_ready, 0);
        end
        checkOutput("hold_valid", frame_valid, 1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        in_valid  = 1'b0;
        checkOutput("ack_valid_clear", frame_valid, 0);
        checkOutput("ack_beat_ignored", ram_wren, 0);
        checkOutput("ack_ready", in_ready, 1);

        $display("[TB] saturation vectors");
        for (int i = 0; i < 12; i++) frame_data[i] = sat_tab[i].din;
        runFrame("sat", 11, 0, 1'b0);
        for (int i = 0; i < 12 && i < got_data.size(); i++)
            checkOutput($sformatf("sat_tab[%0d]", i), got_data[i], sat_tab[i].exp);
        releaseFrame("sat");

        $display("[TB] short frame, in_last on beat 99");
        for (int i = 0; i < FL; i++) frame_data[i] = int'($urandom_range(0, 1023)) - 512;
        runFrame("short", 99, 0, 1'b0);
        releaseFrame("short");

        $display("[TB] missing in_last");
        for (int i = 0; i < FL; i++) frame_data[i] = int'($urandom_range(0, 1023)) - 512;
        runFrame("nolast", -1, 20, 1'b0);
        releaseFrame("nolast");

        $display("[TB] reset after 37 beats");
        for (int i = 0; i < 37; i++) applyStimulus(int'($urandom_range(0, 1023)) - 512, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wren", ram_wren, 0);
        checkOutput("midrst_ready", in_ready, 0);
        checkOutput("midrst_addr", ram_wraddress, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_back", in_ready, 1);

        for (int i = 0; i < FL; i++) frame_data[i] = int'($urandom_range(0, 1023)) - 512;
        runFrame("after_rst", FL - 1, 0, 1'b1);
        for (int i = 0; i < FL; i++) begin
            ram_ref[i]   = ram_model[i];
            ram_model[i] = 8'hxx;
        end
        releaseFrame("after_rst");

        $display("[TB] same frame with random idle gaps");
        runFrame("gaps", FL - 1, 30, 1'b0);
        diff = 0;
        for (int i = 0; i < FL; i++)
            if (ram_model[i] !== ram_ref[i]) diff++;
        checkOutput("gaps_ram_diff", diff, 0);
        releaseFrame("gaps");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/llr_loader.md
Name: llr_loader

Overview:
- Upstream write-side stage of the LLR RAM (8-bit addr, 8-bit data; ports clock/data/wraddress/wren).
- Accepts a valid/ready stream of wide signed channel LLRs, saturates each to LLR_WIDTH and writes one frame sequentially from address 0.
- Hands the filled frame to the decoder via frame_valid/frame_ack, and blocks further input until the frame is released.

Parameters:
- IN_WIDTH, 10, signed input LLR width (must be >= LLR_WIDTH).
- LLR_WIDTH, 8, signed stored LLR width (matches RAM data width).
- ADDR_WIDTH, 8, RAM address width.
- FRAME_LEN, 256, LLRs per frame (2 <= FRAME_LEN <= 2^ADDR_WIDTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  IN_WIDTH  signed channel LLR.
- in_last  in  1  marks final beat of frame.
- ram_wren  out  1  RAM write enable (to RAM wren).
- ram_wraddress  out  ADDR_WIDTH  RAM write address.
- ram_data  out  LLR_WIDTH  saturated LLR (to RAM data).
- frame_valid  out  1  frame fully written, RAM contents stable.
- frame_err  out  1  in_last mismatch detected in current frame.
- frame_len  out  ADDR_WIDTH+1  number of LLRs written in current frame.
- frame_ack  in  1  decoder releases frame (one-cycle pulse).

Behaviour:
- Reset values (async, all outputs registered): in_ready=0, ram_wren=0, ram_wraddress=0, ram_data=0, frame_valid=0, frame_err=0, frame_len=0, state=IDLE, count=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- Beat accepted = in_valid & in_ready at a rising edge.
- States:
  - IDLE: in_ready=1, count=0. Accepted beat -> LOAD; if in_last on that beat, go to DONE instead.
  - LOAD: in_ready=1. Each accepted beat increments count.
  - DONE: in_ready=0, one cycle, waits for the last RAM write to land; then -> HOLD.
  - HOLD: frame_valid=1, in_ready=0. frame_ack -> IDLE; frame_valid, frame_err and frame_len clear on that edge; in_ready=1 on the same edge.
- Frame end (LOAD -> DONE) occurs on the accepted beat where count==FRAME_LEN-1 or in_last=1, whichever comes first. in_ready drops on the same edge.
- Write path, latency 1:
  - Beat accepted at edge T produces ram_wren=1, ram_wraddress=count, ram_data=sat(in_data) during cycle T..T+1.
  - ram_wren=0 in any cycle without an accepted beat in the previous cycle.
  - frame_valid rises at edge T+2 for a last beat accepted at edge T.
- Saturation is symmetric, to [-(2^(LLR_WIDTH-1)-1), +(2^(LLR_WIDTH-1)-1)].
  - Default range is [-127, +127]; in_data=-128 is written as -127 (0x81). Values in range pass unchanged.
- frame_len: count of beats written in the frame, valid while frame_valid=1.
- frame_err set at frame end if either:
  - in_last=1 on a beat with count<FRAME_LEN-1 (short frame; frame_len<FRAME_LEN), or
  - in_last=0 on beat FRAME_LEN-1 (missing last).
- Boundary conditions:
  - Full frame wraps addressing to 0 for the next frame; no address exceeds FRAME_LEN-1.
  - in_valid while in_ready=0 is ignored; upstream must hold data (standard valid/ready).
  - frame_ack outside HOLD is ignored.
  - frame_ack and in_valid in the same HOLD cycle: the beat is not accepted, since in_ready=0 in HOLD.
  - rst_n asserted mid-frame: partial frame discarded, state IDLE, ram_wren drops immediately (async). RAM contents are not cleared.

Test Plan:
- Reset release, then 256 beats with in_data=i-128 (i=0..255), in_valid=1 continuously, in_last on beat 255 -> ram_wraddress 0..255 on consecutive cycles; ram_data follows in_data except beat 0 (-128 written as -127, 0x81); frame_valid 2 cycles after last accept; frame_len=256; frame_err=0.
- Saturation: in_data=+300, -300, +127, -127, 0 -> ram_data=0x7F, 0x81, 0x7F, 0x81, 0x00.
- Backpressure/hold: after frame_valid, drive in_valid=1 for 20 cycles without frame_ack -> no ram_wren, in_ready=0; frame_ack pulse -> frame_valid=0 next edge, next beat written at address 0.
- Short frame: in_last on beat 99 -> frame_valid with frame_len=100, frame_err=1; frame_ack clears both.
- Missing last: 256 beats, in_last never set -> frame ends at beat 255, frame_len=256, frame_err=1.
- Reset mid-frame after 37 beats, then a full frame -> writes restart at address 0, frame_len=256, frame_err=0; in_valid gaps (random 30% idle) give identical RAM contents.
